// File: rtl/shift_engine.sv
// Bit-serial shift/rotate engine: one command per start/busy/done handshake, one bit per clock.
// Rotate modes are built only when SHIFT_ENGINE_ROTATE_EN is defined; otherwise they act as hold.
module shift_engine #(
  parameter  int N  = 8,
  localparam int AW = $clog2(N+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amount,
  input  logic [N-1:0]  data_in,
  input  logic          serial_in,
  output logic [N-1:0]  data_out,
  output logic          serial_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] M_CLR = 3'b000;
  localparam logic [2:0] M_LD  = 3'b111;
  localparam logic [2:0] M_SLL = 3'b100;
  localparam logic [2:0] M_SRL = 3'b001;
  localparam logic [2:0] M_SRA = 3'b011;
  localparam logic [2:0] M_ROL = 3'b110;
  localparam logic [2:0] M_ROR = 3'b010;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    mode_q, mode_d;
  logic [N-1:0]  data_q, data_d;
  logic          sout_q, sout_d;
  logic          done_q, done_d;

  logic [N-1:0]  step_dat;
  logic          step_out;
  logic [AW-1:0] amt_clamped;

  function automatic logic is_shift(input logic [2:0] m);
    case (m)
      M_SLL, M_SRL, M_SRA: return 1'b1;
`ifdef SHIFT_ENGINE_ROTATE_EN
      M_ROL, M_ROR:        return 1'b1;
`endif
      default:             return 1'b0;
    endcase
  endfunction

  assign amt_clamped = (amount > AW'(N)) ? AW'(N) : amount;

  // Single-bit step for the latched mode; step_out is the bit leaving the register.
  always_comb begin
    step_dat = data_q;
    step_out = sout_q;
    case (mode_q)
      M_SLL: begin step_out = data_q[N-1]; step_dat = {data_q[N-2:0], serial_in};   end
      M_SRL: begin step_out = data_q[0];   step_dat = {serial_in, data_q[N-1:1]};   end
      M_SRA: begin step_out = data_q[0];   step_dat = {data_q[N-1], data_q[N-1:1]}; end
`ifdef SHIFT_ENGINE_ROTATE_EN
      M_ROL: begin step_out = data_q[N-1]; step_dat = {data_q[N-2:0], data_q[N-1]}; end
      M_ROR: begin step_out = data_q[0];   step_dat = {data_q[0], data_q[N-1:1]};   end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    data_d  = data_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_shift(mode) && (amt_clamped != '0)) begin
            state_d = SHIFT;
            cnt_d   = amt_clamped;
            mode_d  = mode;
          end else begin
            // Clear, load, hold, disabled rotates and zero-distance shifts finish here.
            done_d = 1'b1;
            if (mode == M_CLR)     data_d = '0;
            else if (mode == M_LD) data_d = data_in;
          end
        end
      end
      SHIFT: begin
        data_d = step_dat;
        sout_d = step_out;
        cnt_d  = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      data_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign data_out   = data_q;
  assign serial_out = sout_q;
  assign busy       = (state_q == SHIFT);
  assign done       = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// Directed plus randomized bench for shift_engine against an arithmetic reference model.
module tb_shift_engine;
  localparam int N  = 8;
  localparam int AW = $clog2(N+1);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amount;
  logic [N-1:0]  data_in;
  logic          serial_in;
  logic [N-1:0]  data_out;
  logic          serial_out;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] m_data;
  logic         m_sout;

  shift_engine #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .amount(amount),
    .data_in(data_in), .serial_in(serial_in), .data_out(data_out),
    .serial_out(serial_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of clocked steps a command takes; 0 means it completes at the accept edge.
  function automatic int steps_for(input logic [2:0] m, input int a);
    int k;
    k = (a > N) ? N : a;
    case (m)
      3'b100, 3'b001, 3'b011: return k;
`ifdef SHIFT_ENGINE_ROTATE_EN
      3'b110, 3'b010:         return k;
`endif
      default:                return 0;
    endcase
  endfunction

  // One step expressed as arithmetic on the register value (p = weight of the MSB).
  task automatic model_step(input logic [2:0] m, input int sin);
    int d, p, msb, lsb;
    d   = int'(m_data);
    p   = 1 << (N-1);
    msb = d / p;
    lsb = d % 2;
    case (m)
      3'b100: begin m_sout = (msb == 1); d = (d * 2) % (2 * p) + sin; end
      3'b001: begin m_sout = (lsb == 1); d = d / 2 + sin * p;         end
      3'b011: begin m_sout = (lsb == 1); d = d / 2 + msb * p;         end
      3'b110: begin m_sout = (msb == 1); d = (d * 2) % (2 * p) + msb; end
      3'b010: begin m_sout = (lsb == 1); d = d / 2 + lsb * p;         end
      default: ;
    endcase
    m_data = N'(d);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle with start low.
  task automatic do_cmd(input logic [2:0] m, input int a, input logic [N-1:0] d,
                        input int sin_sel, input bit poke, input string tag);
    int k;
    k = steps_for(m, a);
    mode = m; amount = AW'(a); data_in = d; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    if (k == 0) begin
      if (m == 3'b000)      m_data = '0;
      else if (m == 3'b111) m_data = d;
    end else begin
      for (int i = 1; i <= k; i++) begin
        int s;
        chk({tag, "/busy"}, busy, 1);
        chk({tag, "/nodone"}, done, 0);
        s = (sin_sel < 0) ? int'($urandom_range(0, 1)) : sin_sel;
        serial_in = s[0];
        if (poke) begin
          mode = 3'b111; data_in = '0;
        end else begin
          mode = 3'($urandom); data_in = N'($urandom);
        end
        amount = AW'($urandom);
        start  = poke;
        @(posedge clock);
        model_step(m, s);
        @(negedge clock);
        start = 1'b0;
        if (i < k) chk({tag, "/mid"}, data_out, m_data);
      end
    end
    chk({tag, "/done"}, done, 1);
    chk({tag, "/busy0"}, busy, 0);
    chk({tag, "/data"}, data_out, m_data);
    chk({tag, "/sout"}, serial_out, m_sout);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "/idle_done"}, done, 0);
    chk({tag, "/idle_busy"}, busy, 0);
    chk({tag, "/idle_data"}, data_out, m_data);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = '0; amount = '0; data_in = '0; serial_in = 1'b0;
    m_data = '0; m_sout = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst/data", data_out, 0);
    chk("rst/sout", serial_out, 0);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    reset = 1'b0;

    do_cmd(3'b111, 0, 8'hA5, -1, 1'b0, "load_a5");
    chk("load_a5/const", data_out, 8'hA5);
    idle_cycle("after_a5");

    do_cmd(3'b111, 0, 8'h81, -1, 1'b0, "load_81");
    do_cmd(3'b100, 3, 8'h00, 1, 1'b0, "sll3");
    chk("sll3/const", data_out, 8'h0F);
    chk("sll3/sout_const", serial_out, 0);

    do_cmd(3'b111, 0, 8'h90, -1, 1'b0, "load_90");
    do_cmd(3'b011, 2, 8'h00, -1, 1'b0, "sra2");
    chk("sra2/const", data_out, 8'hE4);
    do_cmd(3'b011, 12, 8'h00, -1, 1'b0, "sra12");
    chk("sra12/const", data_out, 8'hFF);

    do_cmd(3'b111, 0, 8'h81, -1, 1'b0, "load_81b");
    do_cmd(3'b010, 1, 8'h00, -1, 1'b0, "ror1");
`ifdef SHIFT_ENGINE_ROTATE_EN
    chk("ror1/const", data_out, 8'hC0);
    chk("ror1/sout_const", serial_out, 1);
`else
    chk("ror1/const", data_out, 8'h81);
`endif

    do_cmd(3'b111, 0, 8'hC3, -1, 1'b0, "load_c3");
    do_cmd(3'b001, 4, 8'h00, 0, 1'b1, "srl4_poke");
    chk("srl4_poke/const", data_out, 8'h0C);
    do_cmd(3'b100, 0, 8'h55, -1, 1'b0, "amt0");
    chk("amt0/const", data_out, 8'h0C);
    idle_cycle("after_amt0");

    // Reset lands between the first and second step of a 5-step shift.
    do_cmd(3'b111, 0, 8'h5A, -1, 1'b0, "load_5a");
    mode = 3'b100; amount = AW'(5); serial_in = 1'b1; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst/data", data_out, 0);
    chk("midrst/sout", serial_out, 0);
    chk("midrst/busy", busy, 0);
    chk("midrst/done", done, 0);
    @(negedge clock);
    reset = 1'b0;
    m_data = '0; m_sout = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle_cycle("postrst");
    end
    do_cmd(3'b111, 0, 8'h3C, -1, 1'b0, "load_3c");
    chk("load_3c/const", data_out, 8'h3C);

    for (int i = 0; i < 60; i++) begin
      do_cmd(3'($urandom), int'($urandom_range(0, 15)), N'($urandom), -1,
             bit'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) idle_cycle("rand");
    end
    do_cmd(3'b000, 0, 8'hFF, -1, 1'b0, "clear");
    chk("clear/const", data_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
